// File: rtl/mmss_bcd_timer.sv
// mmss_bcd_timer: minutes:seconds BCD stopwatch / countdown timebase.
// Drives four BCD digits {m_msb, m_lsb, s_msb, s_lsb} for a 4-digit display.
// Define MMSS_COUNTDOWN_EN to build the down-count path (dir honoured, expiry
// at 00:00 enters DONE). Without it the block only counts up and saturates at 99:59.
//
// Controls are single-cycle pulses sampled on the rising clock edge with
// priority clear > load > stop > start. There is no valid/ready handshake:
// every pulse is consumed in the cycle it is presented, and lower-priority
// pulses in that same cycle are dropped.
module mmss_bcd_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        dir,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic        running,
  output logic        done,
  output logic        load_err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          load_err_q, load_err_d;

  logic          tick;
  logic          load_ok;
  logic          count_down;
  logic [15:0]   time_up;
  logic [15:0]   time_dn;

`ifdef MMSS_COUNTDOWN_EN
  assign count_down = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign count_down = 1'b0;
`endif

  // Increment with BCD carry; 99:59 is held (saturation, no wrap).
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] s0, s1, m0, m1;
    {m1, m0, s1, s0} = t;
    if (t == 16'h9959) begin
      return t;
    end
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Decrement with BCD borrow; 00:00 is held (expiry, no wrap).
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] s0, s1, m0, m1;
    {m1, m0, s1, s0} = t;
    if (t == 16'h0000) begin
      return t;
    end
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign tick    = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign time_up = bcd_inc(time_q);
  assign time_dn = bcd_dec(time_q);
  assign load_ok = (load_bcd[3:0]   <= 4'd9) && (load_bcd[7:4]   <= 4'd5) &&
                   (load_bcd[11:8]  <= 4'd9) && (load_bcd[15:12] <= 4'd9);

  // Next-state, next-time, prescaler and error-pulse decode.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    presc_d    = presc_q;
    load_err_d = 1'b0;
    if (clear) begin
      time_d  = 16'h0000;
      presc_d = '0;
      state_d = IDLE;
    end else if (load) begin
      if (load_ok) begin
        time_d  = load_bcd;
        presc_d = '0;
        state_d = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      // A stop edge still advances the prescaler so resume continues the period.
      if (state_q == RUN) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (stop) begin
        if (state_q == RUN) begin
          state_d = IDLE;
        end
      end else if (start && (state_q == IDLE)) begin
        if (count_down && (time_q == 16'h0000)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      // Expiry/saturation wins over a coincident stop.
      if (tick) begin
        if (count_down) begin
          time_d = time_dn;
          if (time_dn == 16'h0000) begin
            state_d = DONE;
          end
        end else begin
          time_d = time_up;
          if (time_up == 16'h9959) begin
            state_d = DONE;
          end
        end
      end
    end
  end

  // State, digit, prescaler and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      time_q     <= 16'h0000;
      presc_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd0     = time_q[3:0];
  assign bcd1     = time_q[7:4];
  assign bcd2     = time_q[11:8];
  assign bcd3     = time_q[15:12];
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign load_err = load_err_q;

endmodule
